// File: rtl/gpio_bus_if.sv
// Host-side register bus for one gpio_ctrl bank: address, strobes and data.
// The host drives the request; the controller returns registered read data.
interface gpio_bus_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       addr;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;

    modport master (
        output addr, wr_en, rd_en, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  addr, wr_en, rd_en, wdata,
        output rdata, rvalid
    );
endinterface

// File: rtl/gpio_ctrl.sv
// Register-mapped controller for one GPIO bank: direction/output registers,
// synchronised pin input, per-pin edge detection and a level interrupt.
module gpio_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    gpio_bus_if.slave        bus,
    output logic [WIDTH-1:0] gpio_dir,
    output logic [WIDTH-1:0] gpio_out,
    input  logic [WIDTH-1:0] gpio_in,
    output logic             irq
);
    localparam logic [2:0] A_DIR     = 3'd0;
    localparam logic [2:0] A_OUT     = 3'd1;
    localparam logic [2:0] A_IN      = 3'd2;
    localparam logic [2:0] A_IRQ_EN  = 3'd3;
    localparam logic [2:0] A_EDGE    = 3'd4;
    localparam logic [2:0] A_STAT    = 3'd5;
    localparam logic [2:0] A_OUT_SET = 3'd6;
    localparam logic [2:0] A_OUT_CLR = 3'd7;
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] dir_r, out_r, en_r, edge_r, stat_r, prev_r, rdata_r;
    logic             rvalid_r, irq_r;
    logic [WIDTH-1:0] sync_r [SYNC_STAGES];

    logic [WIDTH-1:0] sync_in_s, ev_s, clr_s, rd_mux_s;
    logic [WIDTH-1:0] dir_nxt_s, out_nxt_s, en_nxt_s, edge_nxt_s, stat_nxt_s;

    assign sync_in_s = sync_r[SYNC_STAGES-1];
    // Edge polarity is chosen per pin; prev holds last cycle's synchronised level.
    assign ev_s = (edge_r & sync_in_s & ~prev_r) | (~edge_r & ~sync_in_s & prev_r);

    // Write decode: next values of all writable registers.
    always_comb begin
        dir_nxt_s  = dir_r;
        out_nxt_s  = out_r;
        en_nxt_s   = en_r;
        edge_nxt_s = edge_r;
        clr_s      = ZERO;
        if (bus.wr_en) begin
            case (bus.addr)
                A_DIR:     dir_nxt_s  = bus.wdata;
                A_OUT:     out_nxt_s  = bus.wdata;
                A_IRQ_EN:  en_nxt_s   = bus.wdata;
                A_EDGE:    edge_nxt_s = bus.wdata;
                A_STAT:    clr_s      = bus.wdata;
                A_OUT_SET: out_nxt_s  = out_r | bus.wdata;
                A_OUT_CLR: out_nxt_s  = out_r & ~bus.wdata;
                default:   clr_s      = ZERO;
            endcase
        end else begin
            clr_s = ZERO;
        end
        // A new event on a bit outranks a same-cycle W1C of that bit.
        stat_nxt_s = (stat_r & ~clr_s) | ev_s;
    end

    // Read mux; sees pre-write register values so a same-cycle write is not visible.
    always_comb begin
        rd_mux_s = ZERO;
        case (bus.addr)
            A_DIR:     rd_mux_s = dir_r;
            A_OUT:     rd_mux_s = out_r;
            A_IN:      rd_mux_s = sync_in_s;
            A_IRQ_EN:  rd_mux_s = en_r;
            A_EDGE:    rd_mux_s = edge_r;
            A_STAT:    rd_mux_s = stat_r;
            default:   rd_mux_s = ZERO;
        endcase
    end

    // Pin synchroniser chain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= ZERO;
            end
        end else begin
            sync_r[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Control/status registers, edge history, read response and interrupt.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dir_r    <= ZERO;
            out_r    <= ZERO;
            en_r     <= ZERO;
            edge_r   <= ZERO;
            stat_r   <= ZERO;
            prev_r   <= ZERO;
            rdata_r  <= ZERO;
            rvalid_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            dir_r    <= dir_nxt_s;
            out_r    <= out_nxt_s;
            en_r     <= en_nxt_s;
            edge_r   <= edge_nxt_s;
            stat_r   <= stat_nxt_s;
            prev_r   <= sync_in_s;
            rvalid_r <= bus.rd_en;
            irq_r    <= |(stat_r & en_r);
            if (bus.rd_en) begin
                rdata_r <= rd_mux_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign gpio_dir   = dir_r;
    assign gpio_out   = out_r;
    assign irq        = irq_r;
    assign bus.rdata  = rdata_r;
    assign bus.rvalid = rvalid_r;
endmodule
